// File: rtl/key_input_pkg.sv
// Shared types and default timing constants for the key_input board front end.
package key_input_pkg;

    localparam int DATA_W = 32;

    localparam int DEF_SW_W            = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 100000;
    localparam int DEF_REPEAT_DELAY    = 500000;
    localparam int DEF_REPEAT_PERIOD   = 200000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } deb_state_t;

endpackage

// File: rtl/key_input_if.sv
// CPU-side read handshake of key_input: one latched word, a valid flag and a sticky overflow flag.
interface key_input_if;
    import key_input_pkg::*;

    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              overflow;

    modport master (
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  overflow
    );

    modport slave (
        input  rd_en,
        output rd_data,
        output rd_valid,
        output overflow
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus four-state debounce FSM for the confirm button.
// Emits a one-cycle press pulse on acceptance, the debounced level, and a HELD indicator.
module key_debounce
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press,
    output logic level,
    output logic held
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       btn_sync;
    logic             btn;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[0], btn_raw};
        end
    end

    assign btn = btn_sync[1];

    // Saturating increment: the counter can never wrap back into a false "stable" reading.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults first, so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (btn) begin
                    state_next = PRESS_CHK;
                    cnt_next   = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn) begin
                    state_next = IDLE;
                end else if (cnt_inc == CNT_LAST) begin
                    state_next = HELD;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            HELD: begin
                if (!btn) begin
                    state_next = RELEASE_CHK;
                    cnt_next   = '0;
                end
            end
            RELEASE_CHK: begin
                if (btn) begin
                    state_next = HELD;
                end else if (cnt_inc == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The IDLE cycle that saw the first 1 plus DEBOUNCE_CYCLES-1 counting cycles make the full window.
    always_comb begin
        press = (state == PRESS_CHK) && btn && (cnt_inc == CNT_LAST);
        level = (state == HELD) || (state == RELEASE_CHK);
        held  = (state == HELD);
    end

endmodule

// File: rtl/key_input.sv
// Board key-input front end: debounced confirm button samples the slide switches into a CPU-readable word.
// Optional auto-repeat while the button is held: define KEY_INPUT_AUTOREPEAT_EN.
module key_input
    import key_input_pkg::*;
#(
    parameter int SW_W            = DEF_SW_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_raw,
    input  logic            btn_raw,
    key_input_if.slave      cpu
);

    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;
    logic            deb_press;
    logic            deb_level;
    logic            deb_held;
    logic            word_load;

    // Same two-stage depth as the button path, so the sample lines up with the press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
        end
    end

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .press   (deb_press),
        .level   (deb_level),
        .held    (deb_held)
    );

`ifdef KEY_INPUT_AUTOREPEAT_EN
    // After a pulse the counter reloads so the next one lands REPEAT_PERIOD cycles later; needs PERIOD <= DELAY.
    localparam int               REP_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_pulse;
    logic             deb_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= '0;
        end else if (!deb_held) begin
            rep_cnt <= '0;
        end else if (rep_cnt == REP_LAST) begin
            rep_cnt <= REP_RELOAD;
        end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
        end
    end

    assign rep_pulse  = deb_held && (rep_cnt == REP_LAST);
    assign word_load  = deb_press || rep_pulse;
    assign deb_unused = deb_level;
`else
    localparam int REPEAT_UNUSED = REPEAT_DELAY + REPEAT_PERIOD;

    logic [1:0] deb_unused;

    assign word_load  = deb_press;
    assign deb_unused = {deb_level, deb_held};
`endif

    // A load wins over a read; loading onto an unread word without a same-cycle read is an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu.rd_data  <= '0;
            cpu.rd_valid <= 1'b0;
            cpu.overflow <= 1'b0;
        end else if (word_load) begin
            cpu.rd_data  <= DATA_W'(sw_sync);
            cpu.rd_valid <= 1'b1;
            if (cpu.rd_valid && !cpu.rd_en) begin
                cpu.overflow <= 1'b1;
            end
        end else if (cpu.rd_en && cpu.rd_valid) begin
            cpu.rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_input.sv
// Self-checking bench for key_input: directed vector table, hand-written corner sequences,
// and randomized traffic against a run-length reference model.
module tb_key_input;

    localparam int SW_W = 16;
    localparam int DEB  = 4;
    localparam int RDLY = 10;
    localparam int RPER = 5;
`ifdef KEY_INPUT_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic            clk     = 1'b0;
    logic            rst     = 1'b1;
    logic [SW_W-1:0] sw_raw  = '0;
    logic            btn_raw = 1'b0;

    key_input_if bus ();

    key_input #(
        .SW_W            (SW_W),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .btn_raw (btn_raw),
        .cpu     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        btn;
        logic [15:0] sw;
        logic        rd_en;
        logic        valid;
        logic [31:0] data;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic btn, input logic [15:0] sw, input logic rd_en,
                                input logic valid, input logic [31:0] data, input logic ovf);
        vec_t v;
        v.btn   = btn;
        v.sw    = sw;
        v.rd_en = rd_en;
        v.valid = valid;
        v.data  = data;
        v.ovf   = ovf;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic read_once();
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
    endtask

    // Hold the button 10 cycles (accepted on the 6th edge), optionally reading on that edge, then release.
    task automatic press(input logic [15:0] sw, input bit rd_at_accept);
        sw_raw  = sw;
        btn_raw = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            bus.rd_en = rd_at_accept && (n == 6);
            @(posedge clk);
            #1;
        end
        bus.rd_en = 1'b0;
        btn_raw   = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Reference model: the button level seen two edges late flips the debounced level after DEB
    // consecutive disagreeing samples; a held level optionally yields repeats on a fixed schedule.
    bit          m_btn_h [2];
    logic [15:0] m_sw_h  [2];
    bit          m_level;
    int          m_run;
    int          m_held_len;
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_ovf;

    task automatic model_reset();
        m_btn_h[0] = 1'b0;
        m_btn_h[1] = 1'b0;
        m_sw_h[0]  = '0;
        m_sw_h[1]  = '0;
        m_level    = 1'b0;
        m_run      = 0;
        m_held_len = 0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_ovf      = 1'b0;
    endtask

    task automatic model_edge();
        bit          s;
        logic [15:0] sws;
        bit          in_held;
        bit          pulse;
        if (rst) begin
            model_reset();
            return;
        end
        s          = m_btn_h[1];
        sws        = m_sw_h[1];
        m_btn_h[1] = m_btn_h[0];
        m_btn_h[0] = btn_raw;
        m_sw_h[1]  = m_sw_h[0];
        m_sw_h[0]  = sw_raw;
        in_held    = m_level && (m_run == 0);
        pulse      = 1'b0;
        if (AUTOREP) begin
            if (in_held) m_held_len++;
            else         m_held_len = 0;
            if (in_held && m_held_len >= RDLY && ((m_held_len - RDLY) % RPER) == 0) pulse = 1'b1;
        end
        if (s != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = s;
                m_run   = 0;
                if (s) pulse = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        if (pulse) begin
            if (m_valid && !bus.rd_en) m_ovf = 1'b1;
            m_data  = 32'(sws);
            m_valid = 1'b1;
        end else if (bus.rd_en && m_valid) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    int          words;
    bit          exp_v;
    int          seg_left;
    bit          seg_level;

    initial begin
        bus.rd_en = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus.rd_valid), 32'd0);
        check("reset_data",  bus.rd_data,       32'd0);
        check("reset_ovf",   32'(bus.overflow), 32'd0);

        // Clean press, read, ignored read on empty, data holds
        for (int i = 0; i < 5; i++)   vecs.push_back(mk(1'b1, 16'h00A5, 1'b0, 1'b0, 32'h0,  1'b0));
        for (int i = 5; i < 10; i++)  vecs.push_back(mk(1'b1, 16'h00A5, 1'b0, 1'b1, 32'hA5, 1'b0));
        vecs.push_back(mk(1'b0, 16'h00A5, 1'b1, 1'b0, 32'hA5, 1'b0));
        vecs.push_back(mk(1'b0, 16'h1234, 1'b1, 1'b0, 32'hA5, 1'b0));
        for (int i = 12; i < 17; i++) vecs.push_back(mk(1'b0, 16'h1234, 1'b0, 1'b0, 32'hA5, 1'b0));

        rst = 1'b0;
        foreach (vecs[i]) begin
            btn_raw   = vecs[i].btn;
            sw_raw    = vecs[i].sw;
            bus.rd_en = vecs[i].rd_en;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(bus.rd_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_data", i),  bus.rd_data,       vecs[i].data);
            check($sformatf("vec%0d_ovf", i),   32'(bus.overflow), 32'(vecs[i].ovf));
        end
        bus.rd_en = 1'b0;

        // Bounce: single-cycle glitches never produce a word
        for (int n = 0; n < 16; n++) begin
            btn_raw = (n < 4) ? ~n[0] : 1'b0;
            @(posedge clk);
            #1;
            check("bounce_valid", 32'(bus.rd_valid), 32'd0);
        end

        // FSM back in IDLE: a fresh press shows the full latency of DEB+2 edges
        sw_raw  = 16'h0BEE;
        btn_raw = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("latency_edge%0d", n), 32'(bus.rd_valid), 32'(n == 6));
        end
        check("latency_data", bus.rd_data, 32'h0BEE);
        btn_raw = 1'b0;
        read_once();
        repeat (8) @(posedge clk);
        #1;

        // Overflow: second press onto an unread word
        do_reset();
        press(16'h0001, 1'b0);
        check("ovf_first_ovf", 32'(bus.overflow), 32'd0);
        press(16'h0002, 1'b0);
        check("ovf_data",  bus.rd_data,       32'h2);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        check("ovf_valid", 32'(bus.rd_valid), 32'd1);
        read_once();
        check("ovf_read_valid", 32'(bus.rd_valid), 32'd0);
        check("ovf_sticky",     32'(bus.overflow), 32'd1);
        do_reset();
        check("ovf_rst_flag",  32'(bus.overflow), 32'd0);
        check("ovf_rst_data",  bus.rd_data,       32'd0);
        check("ovf_rst_valid", 32'(bus.rd_valid), 32'd0);

        // Simultaneous read and second press pulse
        press(16'h0003, 1'b0);
        check("sim_first_data", bus.rd_data, 32'h3);
        press(16'h0004, 1'b1);
        check("sim_valid", 32'(bus.rd_valid), 32'd1);
        check("sim_data",  bus.rd_data,       32'h4);
        check("sim_ovf",   32'(bus.overflow), 32'd0);
        read_once();

        // Reset mid-hold with the button still pressed
        press(16'h0005, 1'b0);
        sw_raw  = 16'h0005;
        btn_raw = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midhold_ovf_before", 32'(bus.overflow), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midhold_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("midhold_rst_data",  bus.rd_data,       32'd0);
        check("midhold_rst_ovf",   32'(bus.overflow), 32'd0);
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("midhold_edge%0d", n), 32'(bus.rd_valid), 32'(n == 6));
        end
        check("midhold_data", bus.rd_data, 32'h5);
        btn_raw = 1'b0;
        read_once();
        repeat (8) @(posedge clk);
        #1;

        // Long hold, reading every word as it appears
        do_reset();
        sw_raw  = 16'h0077;
        btn_raw = 1'b1;
        words   = 0;
        for (int n = 1; n <= 45; n++) begin
            bus.rd_en = bus.rd_valid;
            if (n == 37) btn_raw = 1'b0;
            @(posedge clk);
            #1;
            exp_v = (n == 6) || (AUTOREP && n >= 16 && n <= 36 && ((n - 16) % 5) == 0);
            check($sformatf("repeat_edge%0d", n), 32'(bus.rd_valid), 32'(exp_v));
            if (bus.rd_valid) words++;
        end
        bus.rd_en = 1'b0;
        check("repeat_words", 32'(words), AUTOREP ? 32'd6 : 32'd1);
        check("repeat_data",  bus.rd_data,       32'h77);
        check("repeat_ovf",   32'(bus.overflow), 32'd0);
        repeat (10) @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        seg_left  = 0;
        seg_level = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (seg_left == 0) begin
                seg_level = $urandom_range(0, 1);
                seg_left  = $urandom_range(1, 30);
            end
            seg_left--;
            btn_raw = seg_level;
            if ($urandom_range(0, 7) == 0) sw_raw = 16'($urandom);
            bus.rd_en = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 599) == 0);
            @(posedge clk);
            model_edge();
            #1;
            check("rand_valid", 32'(bus.rd_valid), 32'(m_valid));
            check("rand_data",  bus.rd_data,       m_data);
            check("rand_ovf",   32'(bus.overflow), 32'(m_ovf));
        end
        rst       = 1'b0;
        bus.rd_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
